eth_r_stream_framer: RTL
========================

# eth_r_stream_framer

Store-and-forward framer that sits directly downstream of the AXI read-channel stream tap. It consumes the captured read-data beat stream (valid/ready/last/data plus declared transaction length), buffers one complete transaction, and emits it on an AXI-Stream master as a header beat followed by the payload beats. The Ethernet packetizer consumes the output.

## Interface
- DATA_WIDTH, 128, width of payload beats and of the output tdata (must be ≥ 32)
- BUF_DEPTH, 63, payload buffer depth in beats (fixed at 63 to match the 6-bit length field)

- clk  input  1  sole clock; all logic is rising-edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  framer can accept a beat
- in_last  input  1  final beat of the transaction
- in_data  input  DATA_WIDTH  beat payload
- in_progress  input  1  upstream transaction open (informational; not used for framing)
- in_length  input  6  declared beat count; sampled on the first accepted beat of each transaction
- m_axis_tvalid  output  1  output beat valid
- m_axis_tready  input  1  downstream ready
- m_axis_tdata  output  DATA_WIDTH  header or payload beat
- m_axis_tlast  output  1  final payload beat of the frame
- busy  output  1  high in any state other than IDLE
- frames_sent  output  16  count of completed frames; wraps 0xFFFF→0

## Operation
- States: IDLE, FILL, HDR, DRAIN.
- IDLE: in_ready=1. On an accepted beat (in_valid & in_ready): write beat to buffer[0], count=1, latch decl=in_length, err=(in_length==0). If in_last is also high, go to HDR; otherwise go to FILL.
- FILL: in_ready=1. Each accepted beat is written at buffer[count] while count<63, and count increments. When count==63, further beats are discarded, count saturates at 63, and err is set. An accepted beat with in_last=1 goes to HDR.
- On entry to HDR: err |= (count != decl).
- HDR: in_ready=0; m_axis_tvalid=1; m_axis_tlast=0.
  - Header tdata[5:0]=count, [11:6]=decl, [12]=err, [15:13]=0, [23:16]=seq, [31:24]=8'hA5, upper bits 0.
  - On handshake go to DRAIN with rd_ptr=0.
- DRAIN: in_ready=0.
  - Presents buffer[rd_ptr] in order, advancing on each handshake.
  - m_axis_tlast=1 on beat count-1.
  - On the tlast handshake: seq+=1 (8-bit wrap), frames_sent+=1, go to IDLE.
- Output holds tdata, tvalid and tlast stable while tvalid=1 and tready=0.
- Buffer is single-port-write/single-port-read RAM. Read latency is hidden by prefetch so DRAIN runs one beat per cycle with tready held high.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 in the following cycle (IDLE); m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; busy=0; frames_sent=0; seq=0; count=0; err=0.
- Reset asserted mid-frame: the frame is abandoned and the buffer is treated as empty. No partial frame is emitted after reset.
- Header valid appears 1 cycle after the cycle in which the in_last beat is accepted.
- Payload beat 0 is valid in the cycle after the header handshake.
- With tready held high, a frame of N beats takes N+1 consecutive output cycles with no bubbles.
- in_ready falls in the cycle after the in_last beat is accepted. It rises in the cycle after the tlast handshake.
- The framer never accepts input and drives output in the same state. Back-to-back frames therefore incur at least 1 idle input cycle.
- in_length is ignored on all beats except the first.

## Test plan
- 4-beat frame, in_length=4, data 0x1..0x4, tready=1 → header tdata[31:0]=0xA5_00_0_104 (count=4, decl=4, err=0, seq=0); then 0x1..0x4 with tlast on 0x4; frames_sent=1.
- Single-beat frame with first-beat in_last=1, in_length=1 → header count=1, err=0; one payload beat with tlast=1.
- Short frame: in_length=8, in_last on beat 3 → header count=3, decl=8, err=1; 3 payload beats.
- Overflow: 70 beats, in_length=63, in_last on beat 70 → count=63, err=1; 63 payload beats equal to the first 63 inputs.
- Backpressure: 5-beat frame with tready toggling 1010… → every beat appears exactly once, tdata stable while stalled; seq increments 0→1 on a second frame.
- Reset asserted during DRAIN beat 2 → next cycle tvalid=0, busy=0, frames_sent=0. A fresh 2-beat frame afterwards shows header seq=0.

Source files
------------

// File: rtl/eth_r_stream_framer.sv
// eth_r_stream_framer: buffers one read transaction and emits it as header + payload on AXI-Stream.
module eth_r_stream_framer #(
  parameter int DATA_WIDTH = 128,
  parameter int BUF_DEPTH  = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_progress,
  input  logic [5:0]            in_length,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [15:0]           frames_sent
);
  typedef enum logic [1:0] {IDLE, FILL, HDR, DRAIN} state_t;
  localparam logic [5:0] FULL = 6'(BUF_DEPTH);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [5:0] count, decl, rd_ptr, cnt_n, decl_n, rd_addr, wr_addr;
  logic [7:0] seq;
  logic [31:0] hdr;
  logic err, err_n, acc, hs, wr_en, unused;
  assign unused = in_progress;
  assign acc = in_valid & in_ready;
  assign hs = m_axis_tvalid & m_axis_tready;
  always_comb begin
    in_ready = ~reset & (state == IDLE || state == FILL);
    m_axis_tvalid = state == HDR || state == DRAIN;
    m_axis_tlast = state == DRAIN && rd_ptr == count - 6'd1;
    busy = state != IDLE;
    cnt_n = state == IDLE ? 6'd1 : (count == FULL ? count : count + 6'd1);
    decl_n = state == IDLE ? in_length : decl;
    err_n = (state == IDLE ? in_length == 6'd0 : (err | count == FULL)) | (in_last & cnt_n != decl_n);
    wr_addr = state == IDLE ? 6'd0 : count;
    wr_en = acc & ~(state == FILL && count == FULL);
    // next read address is prefetched so rd_data already holds the beat to present
    rd_addr = state == DRAIN ? rd_ptr + 6'(hs & ~m_axis_tlast) : 6'd0;
    hdr = {8'hA5, seq, 3'b000, err, decl, count};
    m_axis_tdata = state == HDR ? DATA_WIDTH'(hdr) : (state == DRAIN ? rd_data : '0);
    state_n = state == IDLE ? (acc ? (in_last ? HDR : FILL) : IDLE) :
              state == FILL ? (acc & in_last ? HDR : FILL) :
              state == HDR  ? (hs ? DRAIN : HDR) :
                              (hs & m_axis_tlast ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      decl <= '0;
      err <= 1'b0;
      seq <= '0;
      frames_sent <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      rd_ptr <= rd_addr;
      if (acc) begin
        count <= cnt_n;
        decl <= decl_n;
        err <= err_n;
      end
      if (hs & m_axis_tlast) begin
        seq <= seq + 8'd1;
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
    rd_data <= mem[rd_addr];
  end
endmodule
